// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester
// indices and the default lock budget.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic REQ_M0       = 1'b0;
  localparam logic REQ_M1       = 1'b1;
  localparam int   MAX_LOCK_DEF = 8;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory-port and status signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain, mem_dataout;
  logic          owner, locked, lock_err;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  mem_dataout,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_datain, owner, locked, lock_err
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output mem_dataout,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_datain, owner, locked, lock_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the requester that was not
// granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory/IO port between the MEM stage (m0) and a debug
// master (m1): round-robin with a bounded read-modify-write lock.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  dmem_arbiter_if.slave   bus
);
  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  arb_state_e    state;
  logic          owner_q, lock_err_q, rd_pend, rd_id;
  logic [7:0]    lock_cnt, cnt_next;
  logic [AW-1:0] last_addr, g_addr;
  logic [DW-1:0] last_wdata, g_wdata;
  logic          rr_g0, rr_g1, g0, g1, any_gnt, gid, g_we, g_lock;
  logic          hold_req, hold_lock, cap_hit;

  rr_pick2 u_pick (
    .req0 (bus.m0_req),
    .req1 (bus.m1_req),
    .last (owner_q),
    .gnt0 (rr_g0),
    .gnt1 (rr_g1)
  );

  // Grants depend only on registered state and the held request inputs,
  // which keeps mem_we clean for the memory's low-phase write strobe.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      IDLE:    begin g0 = rr_g0; g1 = rr_g1; end
      LOCK0:   g0 = bus.m0_req;
      LOCK1:   g1 = bus.m1_req;
      default: ;
    endcase
  end

  assign any_gnt   = g0 | g1;
  assign gid       = g1 ? REQ_M1 : REQ_M0;
  assign g_we      = g1 ? bus.m1_we    : bus.m0_we;
  assign g_lock    = g1 ? bus.m1_lock  : bus.m0_lock;
  assign g_addr    = g1 ? bus.m1_addr  : bus.m0_addr;
  assign g_wdata   = g1 ? bus.m1_wdata : bus.m0_wdata;
  assign hold_req  = (state == LOCK1) ? bus.m1_req  : bus.m0_req;
  assign hold_lock = (state == LOCK1) ? bus.m1_lock : bus.m0_lock;

  // cnt_next is the number of grants the owner will have held after this one;
  // the grant that reaches MAX_LOCK is issued but the lock is not kept.
  assign cnt_next = (state == IDLE) ? 8'd1 : lock_cnt + 8'd1;
  assign cap_hit  = any_gnt & g_lock & (cnt_next == MAX_CNT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_q    <= REQ_M1;
      lock_cnt   <= 8'd0;
      lock_err_q <= 1'b0;
      rd_pend    <= 1'b0;
      rd_id      <= REQ_M0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      lock_err_q <= cap_hit;
      rd_pend    <= any_gnt & ~g_we;
      if (any_gnt) begin
        owner_q    <= gid;
        last_addr  <= g_addr;
        last_wdata <= g_wdata;
        if (!g_we) rd_id <= gid;
      end
      case (state)
        IDLE:
          if (any_gnt && g_lock && !cap_hit) begin
            state    <= gid ? LOCK1 : LOCK0;
            lock_cnt <= 8'd1;
          end
        LOCK0, LOCK1:
          if (any_gnt) begin
            if (!g_lock || cap_hit) begin
              state    <= IDLE;
              lock_cnt <= 8'd0;
            end else begin
              lock_cnt <= cnt_next;
            end
          end else if (!hold_req && !hold_lock) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end
        default: begin
          state    <= IDLE;
          lock_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.m0_gnt     = g0;
  assign bus.m1_gnt     = g1;
  assign bus.mem_we     = (g0 & bus.m0_we) | (g1 & bus.m1_we);
  assign bus.mem_addr   = any_gnt ? g_addr  : last_addr;
  assign bus.mem_datain = any_gnt ? g_wdata : last_wdata;
  assign bus.m0_rvalid  = rd_pend & (rd_id == REQ_M0);
  assign bus.m1_rvalid  = rd_pend & (rd_id == REQ_M1);
  assign bus.m0_rdata   = bus.m0_rvalid ? bus.mem_dataout : '0;
  assign bus.m1_rdata   = bus.m1_rvalid ? bus.mem_dataout : '0;
  assign bus.owner      = owner_q;
  assign bus.locked     = (state != IDLE);
  assign bus.lock_err   = lock_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a memory/IO environment, a rule-level
// reference model checked every cycle, and literal checks on key cycles.
module tb_dmem_arbiter;
  localparam int          MAXL = 8;
  localparam logic [31:0] SW   = 32'h0000_02A5;

  logic clock, resetn;
  int   total = 0, bad = 0;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(MAXL)) dut (
    .clock (clock), .resetn (resetn), .bus (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory/IO environment: DRAM below 0x80, switches/LED/HEX above.
  logic [31:0] env_dram [32];
  logic [31:0] env_led, env_hex;
  always @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) env_dram[i] <= 32'hA000_0000 + 32'(i);
      env_led <= 32'h0; env_hex <= 32'h0;
      bus.mem_dataout <= 32'h0;
    end else begin
      if (bus.mem_we) begin
        if (!bus.mem_addr[7]) env_dram[bus.mem_addr[6:2]] <= bus.mem_datain;
        else if (bus.mem_addr[3:2] == 2'd1) env_led <= bus.mem_datain;
        else if (bus.mem_addr[3:2] == 2'd2) env_hex <= bus.mem_datain;
      end
      if (!bus.mem_addr[7]) bus.mem_dataout <= env_dram[bus.mem_addr[6:2]];
      else case (bus.mem_addr[3:2])
        2'd0: bus.mem_dataout <= SW;
        2'd1: bus.mem_dataout <= env_led;
        2'd2: bus.mem_dataout <= env_hex;
        default: bus.mem_dataout <= 32'h0;
      endcase
    end
  end

  // Reference model: who owns the lock, how many grants it has taken, who
  // was served last, and the one read that is in flight.
  logic [31:0] ref_dram [32];
  logic [31:0] ref_led, ref_hex, m_addr, m_wdata, p_data;
  int          hold, nheld, last, p_id;
  bit          pend, err;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (!a[7]) return ref_dram[a[6:2]];
    case (a[3:2])
      2'd0: return SW;
      2'd1: return ref_led;
      2'd2: return ref_hex;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clock) begin : cmp
    bit          r [2], w [2], l [2], e [2];
    logic [31:0] a [2], d [2];
    int          g;
    if (!resetn) begin
      chk("rst_owner", 32'(bus.owner), 32'd1);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_lock_err", 32'(bus.lock_err), 32'd0);
      chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      chk("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_datain", bus.mem_datain, 32'd0);
      for (int i = 0; i < 32; i++) ref_dram[i] = 32'hA000_0000 + 32'(i);
      ref_led = 0; ref_hex = 0; m_addr = 0; m_wdata = 0;
      hold = -1; nheld = 0; last = 1; pend = 0; err = 0; p_id = 0; p_data = 0;
    end else begin
      r[0] = bus.m0_req; w[0] = bus.m0_we; l[0] = bus.m0_lock; a[0] = bus.m0_addr; d[0] = bus.m0_wdata;
      r[1] = bus.m1_req; w[1] = bus.m1_we; l[1] = bus.m1_lock; a[1] = bus.m1_addr; d[1] = bus.m1_wdata;
      e[0] = 0; e[1] = 0;
      if (hold >= 0)         e[hold] = r[hold];
      else if (r[0] && r[1]) e[1 - last] = 1;
      else begin e[0] = r[0]; e[1] = r[1]; end
      g = e[1] ? 1 : 0;
      chk("gnt0", 32'(bus.m0_gnt), 32'(e[0]));
      chk("gnt1", 32'(bus.m1_gnt), 32'(e[1]));
      chk("mem_we", 32'(bus.mem_we), 32'((e[0] || e[1]) && w[g]));
      chk("mem_addr", bus.mem_addr, (e[0] || e[1]) ? a[g] : m_addr);
      chk("mem_datain", bus.mem_datain, (e[0] || e[1]) ? d[g] : m_wdata);
      chk("rvalid0", 32'(bus.m0_rvalid), 32'(pend && p_id == 0));
      chk("rvalid1", 32'(bus.m1_rvalid), 32'(pend && p_id == 1));
      chk("rdata0", bus.m0_rdata, (pend && p_id == 0) ? p_data : 32'h0);
      chk("rdata1", bus.m1_rdata, (pend && p_id == 1) ? p_data : 32'h0);
      chk("owner", 32'(bus.owner), 32'(last));
      chk("locked", 32'(bus.locked), 32'(hold >= 0));
      chk("lock_err", 32'(bus.lock_err), 32'(err));
      pend = 0; err = 0;
      if (e[0] || e[1]) begin
        last = g; m_addr = a[g]; m_wdata = d[g];
        if (!w[g]) begin
          pend = 1; p_id = g; p_data = ref_rd(a[g]);
        end else if (!a[g][7]) ref_dram[a[g][6:2]] = d[g];
        else if (a[g][3:2] == 2'd1) ref_led = d[g];
        else if (a[g][3:2] == 2'd2) ref_hex = d[g];
        if (l[g]) begin
          if (hold < 0) begin hold = g; nheld = 0; end
          nheld++;
          if (nheld == MAXL) begin hold = -1; err = 1; end
        end else hold = -1;
      end else if (hold >= 0 && !r[hold] && !l[hold]) hold = -1;
    end
  end

  task automatic set_m0(input bit rq, input bit we, input bit lk, input logic [31:0] ad, input logic [31:0] wd);
    bus.m0_req = rq; bus.m0_we = we; bus.m0_lock = lk; bus.m0_addr = ad; bus.m0_wdata = wd;
  endtask
  task automatic set_m1(input bit rq, input bit we, input bit lk, input logic [31:0] ad, input logic [31:0] wd);
    bus.m1_req = rq; bus.m1_we = we; bus.m1_lock = lk; bus.m1_addr = ad; bus.m1_wdata = wd;
  endtask
  task automatic mid();  @(negedge clock); #1; endtask
  task automatic next(); @(posedge clock); #1; endtask

  initial begin
    resetn = 1'b0;
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("lit_rst_owner", 32'(bus.owner), 32'd1);
    chk("lit_rst_mem_addr", bus.mem_addr, 32'd0);
    resetn = 1'b1;

    // Simultaneous reads: m0 first, then m1, data one cycle after each grant.
    set_m0(1, 0, 0, 32'h10, 0); set_m1(1, 0, 0, 32'h80, 0);
    mid(); chk("lit_t1_gnt0", 32'(bus.m0_gnt), 32'd1); chk("lit_t1_gnt1", 32'(bus.m1_gnt), 32'd0);
    next(); set_m0(0, 0, 0, 0, 0);
    mid(); chk("lit_t1_gnt1b", 32'(bus.m1_gnt), 32'd1);
    chk("lit_t1_rdata0", bus.m0_rdata, 32'hA000_0004);
    next(); set_m1(0, 0, 0, 0, 0);
    mid(); chk("lit_t1_rvalid1", 32'(bus.m1_rvalid), 32'd1); chk("lit_t1_rdata1", bus.m1_rdata, SW);
    next();

    // Six contended unlocked cycles alternate.
    set_m0(1, 0, 0, 32'h00, 0); set_m1(1, 0, 0, 32'h04, 0);
    for (int k = 0; k < 6; k++) begin
      mid(); chk("lit_alt_gnt0", 32'(bus.m0_gnt), 32'(k % 2 == 0));
      next();
    end
    set_m1(0, 0, 0, 0, 0);
    next(); set_m0(0, 0, 0, 0, 0);
    next();

    // m1 locked write then unlocked read of the LEDs; m0 waits two cycles.
    set_m0(1, 0, 0, 32'h08, 0); set_m1(1, 1, 1, 32'h84, 32'h3FF);
    mid(); chk("lit_rmw_gnt1a", 32'(bus.m1_gnt), 32'd1); chk("lit_rmw_we", 32'(bus.mem_we), 32'd1);
    chk("lit_rmw_datain", bus.mem_datain, 32'h3FF);
    next(); set_m1(1, 0, 0, 32'h84, 0);
    mid(); chk("lit_rmw_gnt0b", 32'(bus.m0_gnt), 32'd0); chk("lit_rmw_locked", 32'(bus.locked), 32'd1);
    next(); set_m1(0, 0, 0, 0, 0);
    mid(); chk("lit_rmw_gnt0c", 32'(bus.m0_gnt), 32'd1); chk("lit_rmw_rdata1", bus.m1_rdata, 32'h3FF);
    next(); set_m0(0, 0, 0, 0, 0);
    set_m1(1, 0, 0, 32'h0C, 0);
    next(); set_m1(0, 0, 0, 0, 0);
    next();

    // m0 holds lock for 12 cycles: 8 grants, forced break, m1 served.
    set_m0(1, 0, 1, 32'h00, 0); set_m1(1, 0, 0, 32'h04, 0);
    for (int k = 0; k < 12; k++) begin
      mid();
      chk("lit_cap_gnt0", 32'(bus.m0_gnt), 32'(k != 8));
      chk("lit_cap_lock_err", 32'(bus.lock_err), 32'(k == 8));
      next();
    end
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    next(); next();

    // Read, write, read of the same DRAM word back-to-back.
    set_m0(1, 0, 0, 32'h20, 0);
    next(); set_m0(1, 1, 0, 32'h20, 32'hDEADBEEF);
    mid(); chk("lit_rw_rdata_old", bus.m0_rdata, 32'hA000_0008);
    next(); set_m0(1, 0, 0, 32'h20, 0);
    mid(); chk("lit_rw_no_rvalid", 32'(bus.m0_rvalid), 32'd0);
    next(); set_m0(0, 0, 0, 0, 0);
    mid(); chk("lit_rw_rdata_new", bus.m0_rdata, 32'hDEADBEEF);
    next();

    // Reset while m1 holds the lock with a read outstanding.
    set_m1(1, 0, 1, 32'h80, 0);
    next(); set_m1(1, 0, 1, 32'h84, 0);
    next(); set_m1(0, 0, 1, 0, 0);
    #1; chk("lit_pre_rst_rvalid1", 32'(bus.m1_rvalid), 32'd1);
    chk("lit_pre_rst_locked", 32'(bus.locked), 32'd1);
    #1; resetn = 1'b0; set_m1(0, 0, 0, 0, 0);
    #1; chk("lit_rst_rvalid1", 32'(bus.m1_rvalid), 32'd0);
    chk("lit_rst_locked", 32'(bus.locked), 32'd0);
    chk("lit_rst_rdata1", bus.m1_rdata, 32'd0);
    next(); resetn = 1'b1;
    next(); next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the shared data-memory/IO block (word DRAM at addr[7]=0, memory-mapped switches/LEDs/HEX at addr[7]=1). It shares the single memory port between the pipeline MEM stage (requester 0) and a debug/loader master (requester 1). Arbitration is round-robin with an optional bounded lock for read-modify-write sequences. Read data is returned with a one-cycle valid strobe.

## Interface

- `AW`, default 32: address width, passed through unchanged.
- `DW`, default 32: data width.
- `MAX_LOCK`, default 8: maximum consecutive grants a locked owner may hold, range 1..255.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held with its fields until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  keep ownership after this grant.
- `m0_addr`, `m1_addr`  in  AW  byte address.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_gnt`, `m1_gnt`  out  1  combinational; the access is accepted at this edge.
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, registered.
- `m0_rdata`, `m1_rdata`  out  DW  read data; valid while the matching rvalid is high.
- `mem_we`, `mem_addr`, `mem_datain`  out  1/AW/DW  drive the memory block.
- `mem_dataout`  in  DW  memory read data, valid one cycle after issue.
- `owner`  out  1  last granted requester.
- `locked`  out  1  lock currently held.
- `lock_err`  out  1  one-cycle pulse when a lock is forcibly broken.

## Operation

- FSM states: IDLE, LOCK0, LOCK1.
- IDLE, one requester active: grant it.
- IDLE, both active: grant the requester that is not `owner`.
- Every grant sets `owner` to the granted index.
- If the granted requester has lock=1, go to LOCK<i> and load `lock_cnt` with 1.
- LOCK<i>: only requester i can be granted. The other requester's gnt stays 0 even when its req is high.
- Each grant in LOCK<i> increments `lock_cnt`.
- LOCK<i> returns to IDLE on either of:
  - a grant with lock=0, or
  - a cycle in which m<i>_req is 0 while lock is 0.
- Owner still requests lock=1 when `lock_cnt`=MAX_LOCK: that grant is issued, then:
  - force return to IDLE;
  - pulse `lock_err`;
  - the next contended grant goes to the other requester.
- mem_* outputs:
  - With a grant, they mux the granted requester's addr/wdata; `mem_we` = granted we.
  - Without a grant, `mem_we`=0 and addr/datain hold the last granted values.
- Read completion:
  - A granted read sets a `rd_pend` flag and a `rd_id` register.
  - Next cycle: m<rd_id>_rvalid=1 and m<rd_id>_rdata = `mem_dataout`.
  - Non-target rdata is 0.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle. rvalid for grant N coincides with grant N+1.

## Timing

- Reset values: state IDLE; `owner`=1, so requester 0 wins first contention; `locked`=0; `lock_cnt`=0; `lock_err`=0; all rvalid=0; all rdata=0; `mem_we`=0; `mem_addr`=0; `mem_datain`=0.
- Reset asserted mid-read or mid-lock: the pending rvalid is dropped and the lock is released.
- Grant latency: 0 cycles from req when uncontended.
- Worst-case wait for an unlocked requester: MAX_LOCK+1 cycles.
- Read data latency: exactly 1 cycle after the grant edge.
- `mem_we` is registered nowhere here. The memory block qualifies it with the low clock phase, so `mem_we` must be glitch-free: it is decoded only from state plus held inputs.
- Simultaneous lock request from both in IDLE: the round-robin winner locks; the loser waits.

## Structure

- Shared package `dmem_pkg`:
  - FSM state encoding (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2);
  - requester index constants;
  - `MAX_LOCK` default.
- One natural sub-module, `rr_pick2`: a combinational two-way round-robin selector (`req0`, `req1`, `last` → `gnt0`, `gnt1`).
- Lock counter, `rd_pend`/`rd_id` and the output muxes stay in the top.

## Test plan

- Reset → all outputs 0, `owner`=1.
- Then m0 and m1 read 0x10 and 0x80 in the same cycle:
  - m0_gnt first;
  - m1_gnt next cycle;
  - m0_rvalid with DRAM word, then m1_rvalid with switch value.
- Both requesters hold req for 6 cycles unlocked → grants alternate 0,1,0,1,0,1.
- m1 writes 0x84 = 0x3FF with lock=1, then reads 0x84 with lock=0, while m0 requests throughout:
  - m0 is blocked for both cycles;
  - m0 is granted on the third cycle.
- m0 holds lock=1 and req for 12 cycles with MAX_LOCK=8, m1 requesting:
  - 8 grants to m0;
  - `lock_err` pulses;
  - next grant goes to m1.
- m0 reads 0x20 then writes 0x20 = 0xDEADBEEF back-to-back, then reads it again → second rvalid returns 0xDEADBEEF.
- `resetn` dropped during LOCK1 with a read pending → no rvalid; state IDLE; `locked`=0 immediately.
